// File: rtl/div_seq_if.sv
// Request/response bundle for the sequential divider: one-shot start with operands,
// annul flush, and the stall/ready/HI-LO result path back to the pipeline.
interface div_seq_if #(parameter int DW = 32);
  logic          start;
  logic          signed_div;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic          annul;
  logic          stall_o;
  logic          ready_o;
  logic [2*DW-1:0] hilo_o;
  logic          div_zero_o;

  modport master (output start, signed_div, a, b, annul,
                  input  stall_o, ready_o, hilo_o, div_zero_o);
  modport slave  (input  start, signed_div, a, b, annul,
                  output stall_o, ready_o, hilo_o, div_zero_o);
endinterface

// File: rtl/div_seq.sv
// Multi-cycle restoring divider (DIV/DIVU), one quotient bit per cycle, HI=rem LO=quot.
// Optional macro DIV_ZERO_FLAG_EN enables the divide-by-zero flag on div_zero_o.
module div_seq #(parameter int DW = 32) (
  input  logic     clk,
  input  logic     resetn,
  div_seq_if.slave bus
);
  localparam int CW = $clog2(DW) + 1;

  typedef enum logic [1:0] {IDLE, CALC, ZERO, DONE} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]   cnt;
  logic [DW-1:0]   rem_q, quo_q, dvs_q;
  logic [2*DW-1:0] hilo_q;
  logic            neg_q, neg_r;

  logic            accept, last;
  logic [DW-1:0]   a_mag, b_mag;
  logic [DW:0]     shl, diff;
  logic            ge;
  logic [DW-1:0]   rem_nxt, quo_nxt, q_fin, r_fin;

  assign accept = (state == IDLE) && bus.start && !bus.annul;
  assign last   = (state == CALC) && (cnt == CW'(DW-1));

  assign a_mag = (bus.signed_div && bus.a[DW-1]) ? -bus.a : bus.a;
  assign b_mag = (bus.signed_div && bus.b[DW-1]) ? -bus.b : bus.b;

  // quo_q starts as the dividend magnitude and shifts out into the remainder
  // as quotient bits shift in from the bottom.
  assign shl     = {rem_q, quo_q[DW-1]};
  assign diff    = shl - {1'b0, dvs_q};
  assign ge      = ~diff[DW];
  assign rem_nxt = ge ? diff[DW-1:0] : shl[DW-1:0];
  assign quo_nxt = {quo_q[DW-2:0], ge};
  assign q_fin   = neg_q ? -quo_nxt : quo_nxt;
  assign r_fin   = neg_r ? -rem_nxt : rem_nxt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.annul) state_nxt = IDLE;
    else begin
      case (state)
        IDLE: if (bus.start) state_nxt = (b_mag == '0) ? ZERO : CALC;
        CALC: if (last) state_nxt = DONE;
        ZERO: state_nxt = DONE;
        DONE: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt    <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      hilo_q <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else if (accept) begin
      cnt   <= '0;
      rem_q <= '0;
      quo_q <= a_mag;
      dvs_q <= b_mag;
      neg_q <= bus.signed_div & (bus.a[DW-1] ^ bus.b[DW-1]);
      neg_r <= bus.signed_div & bus.a[DW-1];
    end else if (state == CALC && !bus.annul) begin
      cnt   <= cnt + CW'(1);
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
      if (last) hilo_q <= {r_fin, q_fin};
    end else if (state == ZERO && !bus.annul) begin
      hilo_q <= '0;
    end
  end

  // Gated by resetn so stall drops immediately on reset even with start high.
  assign bus.stall_o = resetn && !bus.annul &&
                       ((state == IDLE && bus.start) || state == CALC || state == ZERO);
  assign bus.ready_o = (state == DONE) && !bus.annul;
  assign bus.hilo_o  = hilo_q;

`ifdef DIV_ZERO_FLAG_EN
  logic zero_q;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     zero_q <= 1'b0;
    else if (accept) zero_q <= (b_mag == '0);
  end
  assign bus.div_zero_o = bus.ready_o & zero_q;
`else
  assign bus.div_zero_o = 1'b0;
`endif
endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: reset, DIVU/DIV vectors, divide-by-zero, annul, reset abort.
module tb_div_seq;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   errors = 0;

`ifdef DIV_ZERO_FLAG_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  div_seq_if #(.DW(DW)) bus ();
  div_seq #(.DW(DW)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    bus.start = 1'b1; bus.annul = 1'b0; bus.signed_div = 1'b0;
    bus.a = 32'd100; bus.b = 32'd7;
    tick; tick;
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", bus.stall_o); end
    checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", bus.ready_o); end
    checks++; if (bus.hilo_o !== 64'h0) begin errors++; $display("FAIL reset_hilo got=%h exp=0", bus.hilo_o); end
    checks++; if (bus.div_zero_o !== 1'b0) begin errors++; $display("FAIL reset_dz got=%b exp=0", bus.div_zero_o); end
    bus.start = 1'b0;
    #1 resetn = 1'b1;
    tick;
  endtask

  // Issue one op in the current (IDLE) cycle and follow it to the ready pulse.
  task automatic run_div(input logic [31:0] da, input logic [31:0] db, input logic sgn,
                         input logic [63:0] exp_hilo, input logic exp_dz,
                         input int exp_lat, input string nm);
    int  lat;
    bit  seen;
    bit  stall_bad;
    bus.a = da; bus.b = db; bus.signed_div = sgn; bus.start = 1'b1;
    #1;
    checks++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL %s_stall_t0 got=%b exp=1", nm, bus.stall_o); end
    tick;
    // Scramble operands: the latched values must be used.
    bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom; bus.signed_div = ~sgn;
    lat = 1; seen = 1'b0; stall_bad = 1'b0;
    while (lat <= 40 && !seen) begin
      if (bus.ready_o === 1'b1) seen = 1'b1;
      else begin
        if (bus.stall_o !== 1'b1) stall_bad = 1'b1;
        tick; lat++;
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL %s_timeout no ready within 40 cycles", nm); end
    checks++; if (stall_bad) begin errors++; $display("FAIL %s_stall_busy stall dropped before ready", nm); end
    if (seen) begin
      checks++; if (lat != exp_lat) begin errors++; $display("FAIL %s_latency got=%0d exp=%0d", nm, lat, exp_lat); end
      checks++; if (bus.hilo_o !== exp_hilo) begin errors++; $display("FAIL %s_hilo got=%h exp=%h", nm, bus.hilo_o, exp_hilo); end
      checks++; if (bus.div_zero_o !== exp_dz) begin errors++; $display("FAIL %s_dz got=%b exp=%b", nm, bus.div_zero_o, exp_dz); end
      checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL %s_stall_done got=%b exp=0", nm, bus.stall_o); end
      tick;
      checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL %s_ready_pulse got=%b exp=0", nm, bus.ready_o); end
      checks++; if (bus.hilo_o !== exp_hilo) begin errors++; $display("FAIL %s_hilo_hold got=%h exp=%h", nm, bus.hilo_o, exp_hilo); end
    end
  endtask

  task automatic test_divu;
    run_div(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 1'b0, 33, "divu_100_7");
    run_div(32'hFFFFFFFF, 32'h10, 1'b0, 64'h0000000F_0FFFFFFF, 1'b0, 33, "divu_max_16");
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b0, 64'h80000000_00000000, 1'b0, 33, "divu_min_m1");
  endtask

  task automatic test_signed;
    run_div(32'hFFFFFFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 1'b0, 33, "div_m7_2");
    run_div(32'd7, 32'hFFFFFFFE, 1'b1, 64'h00000001_FFFFFFFD, 1'b0, 33, "div_7_m2");
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, 1'b0, 33, "div_ovf");
    run_div(32'hFFFFFF9C, 32'd7, 1'b1, 64'hFFFFFFFE_FFFFFFF2, 1'b0, 33, "div_m100_7");
  endtask

  task automatic test_div_zero;
    run_div(32'd5, 32'd0, 1'b0, 64'h0, DZ_EN, 2, "divu_by0");
    run_div(32'hFFFFFFF0, 32'd0, 1'b1, 64'h0, DZ_EN, 2, "div_by0");
  endtask

  task automatic test_back_to_back;
    run_div(32'd50, 32'd6, 1'b0, 64'h00000002_00000008, 1'b0, 33, "b2b_first");
    // run_div ends one cycle after DONE, i.e. the IDLE cycle right after the pulse
    run_div(32'd9, 32'd0, 1'b0, 64'h0, DZ_EN, 2, "b2b_zero");
    run_div(32'd1000, 32'd10, 1'b0, 64'h00000000_00000064, 1'b0, 33, "b2b_third");
  endtask

  task automatic test_annul;
    bit rdy_seen;
    bus.a = 32'd100; bus.b = 32'd7; bus.signed_div = 1'b0; bus.start = 1'b1;
    tick;                                   // T0+1
    bus.start = 1'b0;
    rdy_seen = 1'b0;
    for (int i = 1; i < 10; i++) begin
      if (bus.ready_o === 1'b1) rdy_seen = 1'b1;
      tick;
    end
    bus.annul = 1'b1; bus.start = 1'b1;     // T0+10, annul beats start
    #1;
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL annul_stall got=%b exp=0", bus.stall_o); end
    checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL annul_ready got=%b exp=0", bus.ready_o); end
    tick;                                   // T0+11
    bus.annul = 1'b0; bus.start = 1'b0;
    #1;
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL annul_idle_stall got=%b exp=0", bus.stall_o); end
    if (bus.ready_o === 1'b1) rdy_seen = 1'b1;
    checks++; if (rdy_seen) begin errors++; $display("FAIL annul_no_ready got=1 exp=0"); end
    tick;                                   // T0+12
    run_div(32'd9, 32'd3, 1'b0, 64'h00000000_00000003, 1'b0, 33, "after_annul");

    // Annul landing on the DONE cycle must kill the pulse.
    bus.a = 32'd8; bus.b = 32'd2; bus.signed_div = 1'b0; bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    for (int i = 1; i < 33; i++) tick;
    bus.annul = 1'b1;
    #1;
    checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL annul_done_ready got=%b exp=0", bus.ready_o); end
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL annul_done_stall got=%b exp=0", bus.stall_o); end
    tick;
    bus.annul = 1'b0;
    #1;
    checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL annul_done_after got=%b exp=0", bus.ready_o); end
    tick;
  endtask

  task automatic test_reset_mid;
    bit rdy_seen;
    bus.a = 32'd77; bus.b = 32'd5; bus.signed_div = 1'b0; bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    for (int i = 1; i < 5; i++) tick;       // T0+5
    bus.start = 1'b1;
    #1 resetn = 1'b0;
    #1;
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL rstmid_stall got=%b exp=0", bus.stall_o); end
    checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL rstmid_ready got=%b exp=0", bus.ready_o); end
    checks++; if (bus.hilo_o !== 64'h0) begin errors++; $display("FAIL rstmid_hilo got=%h exp=0", bus.hilo_o); end
    checks++; if (bus.div_zero_o !== 1'b0) begin errors++; $display("FAIL rstmid_dz got=%b exp=0", bus.div_zero_o); end
    bus.start = 1'b0;
    tick;
    resetn = 1'b1;
    rdy_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.ready_o === 1'b1) rdy_seen = 1'b1;
      tick;
    end
    checks++; if (rdy_seen) begin errors++; $display("FAIL rstmid_no_ready got=1 exp=0"); end

    // start with annul in IDLE: no stall and nothing launched
    bus.a = 32'd12; bus.b = 32'd4; bus.start = 1'b1; bus.annul = 1'b1;
    #1;
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL idle_annul_stall got=%b exp=0", bus.stall_o); end
    tick;
    bus.start = 1'b0; bus.annul = 1'b0;
    #1;
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL idle_annul_stays got=%b exp=0", bus.stall_o); end
    tick;
    run_div(32'd12, 32'd4, 1'b0, 64'h00000000_00000003, 1'b0, 33, "post_reset");
  endtask

  initial begin
    bus.start = 1'b0; bus.annul = 1'b0; bus.signed_div = 1'b0;
    bus.a = '0; bus.b = '0;
    test_reset;
    test_divu;
    test_signed;
    test_div_zero;
    test_back_to_back;
    test_annul;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
